// File: rtl/cpu_pkg.sv
// Shared constants and types for the CPU register-file write path.
// Defaults for the address and data widths, the hard-wired zero register,
// and the state type of the write-port arbiter.
package cpu_pkg;

    localparam int DEF_REG_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH     = 32;

    // Writes to this register index are discarded (it always reads as zero).
    localparam int ZERO_REG = 0;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_grant_picker.sv
// One-hot grant picker: scans the request vector starting at index 'start',
// ascending with wrap-around, and grants the first requester found.
// With start tied to zero this degenerates to lowest-index-wins priority.
module rr_grant_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start,
    output logic [NUM_REQ-1:0] grant
);

    // Rotating scan from 'start'; the first set request bit wins.
    always_comb begin
        int               sum;
        logic [IDX_W-1:0] idx;
        logic             found;
        grant = '0;
        found = 1'b0;
        sum   = 0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = int'(start) + k;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            idx = IDX_W'(sum);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter.
// Shares the single register-file write port between NUM_REQ writers
// (0: decoder MOVI, 1: ALU writeback, 2: load unit), supports locked
// multi-beat bursts bounded by LOCK_MAX, and suppresses writes to the zero
// register. The accepted beat is presented one cycle later on rf_wr_*.
//
// Build option: define RR_ARB_EN for round-robin selection in IDLE (search
// starts at ptr). Without it, the lowest valid index wins and no pointer
// register exists.
//
// Handshake: a requester raises req_valid with addr/data/lock and holds them
// stable until it sees req_ready; a beat transfers in the cycle where
// req_valid & req_ready are both high. req_ready is at most one-hot, is
// combinational from req_valid/state/ptr, and is never raised for a
// requester whose req_valid is low.
module regfile_write_arbiter
    import cpu_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int LOCK_MAX       = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ-1:0]                 req_lock,
    input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_data,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic                               rf_wr_en,
    output logic [REG_ADDR_WIDTH-1:0]          rf_wr_addr,
    output logic [DATA_WIDTH-1:0]              rf_wr_data,
    output logic                               arb_locked
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    arb_state_t                state_q, state_d;
    logic [IDX_W-1:0]          owner_q, owner_d;
    logic [CNT_W-1:0]          beat_q, beat_d, beat_inc;
    logic [IDX_W-1:0]          start_idx;
    logic [NUM_REQ-1:0]        pick_grant;
    logic [IDX_W-1:0]          gnt_idx;
    logic                      accept;
    logic [REG_ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]     sel_data;
    logic                      sel_lock;

`ifdef RR_ARB_EN
    logic [IDX_W-1:0] ptr_q;

    // Round-robin pointer: one past the index granted on every accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (accept) begin
            ptr_q <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end
    end

    assign start_idx = ptr_q;
`else
    assign start_idx = '0;
`endif

    rr_grant_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req   (req_valid),
        .start (start_idx),
        .grant (pick_grant)
    );

    // Ready: locked owner only while LOCKED, picker result while IDLE, nothing in reset.
    always_comb begin
        req_ready = '0;
        if (!rst) begin
            if (state_q == LOCKED) begin
                req_ready[owner_q] = req_valid[owner_q];
            end else begin
                req_ready = pick_grant;
            end
        end
    end

    // Granted index and the selected beat's fields.
    always_comb begin
        gnt_idx  = '0;
        sel_addr = '0;
        sel_data = '0;
        sel_lock = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                gnt_idx  = IDX_W'(i);
                sel_addr = req_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
                sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_lock = req_lock[i];
            end
        end
    end

    assign accept = |req_ready;

    // Next state: enter LOCKED on a locked beat, leave on unlock or when the burst hits LOCK_MAX.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        beat_d   = beat_q;
        beat_inc = beat_q + CNT_W'(1);
        if (accept) begin
            case (state_q)
                IDLE: begin
                    // With LOCK_MAX of 1 a lock can never grant a second beat, so stay IDLE.
                    if (sel_lock && (LOCK_MAX > 1)) begin
                        state_d = LOCKED;
                        owner_d = gnt_idx;
                        beat_d  = CNT_W'(1);
                    end
                end
                LOCKED: begin
                    if (!sel_lock || (beat_inc == CNT_W'(LOCK_MAX))) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    beat_d  = '0;
                end
            endcase
        end
    end

    // FSM state, burst owner and beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            beat_q  <= beat_d;
        end
    end

    // Output register: capture the accepted beat; zero-register writes keep enable low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wr_en   <= 1'b0;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
        end else if (accept) begin
            rf_wr_en   <= (sel_addr != REG_ADDR_WIDTH'(ZERO_REG));
            rf_wr_addr <= sel_addr;
            rf_wr_data <= sel_data;
        end else begin
            rf_wr_en   <= 1'b0;
        end
    end

    assign arb_locked = (state_q == LOCKED);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed per-cycle vectors with
// hand-computed grants; expected register-file writes go into a queue that
// a separate monitor drains whenever rf_wr_en is high.
module tb_regfile_write_arbiter;

    localparam int NUM_REQ = 3;
    localparam int RAW     = 5;
    localparam int DW      = 32;

    logic                    clk;
    logic                    rst;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_lock;
    logic [NUM_REQ*RAW-1:0]  req_addr;
    logic [NUM_REQ*DW-1:0]   req_data;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    rf_wr_en;
    logic [RAW-1:0]          rf_wr_addr;
    logic [DW-1:0]           rf_wr_data;
    logic                    arb_locked;

    logic [RAW-1:0]          addr_r [NUM_REQ];
    logic [DW-1:0]           data_r [NUM_REQ];

    logic [RAW+DW-1:0]       exp_q [$];
    logic                    prev_wr;
    int                      tests;
    int                      fails;

    regfile_write_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .REG_ADDR_WIDTH (RAW),
        .DATA_WIDTH     (DW),
        .LOCK_MAX       (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_lock   (req_lock),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .arb_locked (arb_locked)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack per-requester address/data into the flattened buses.
    always_comb begin
        req_addr = '0;
        req_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i*RAW +: RAW] = addr_r[i];
            req_data[i*DW +: DW]   = data_r[i];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One arbitration cycle: drive inputs, check ready/lock/previous-write enable
    // at the falling edge, queue the expected write, then step past the rising edge.
    task automatic cycle(input string name, input logic [NUM_REQ-1:0] v,
                         input logic [NUM_REQ-1:0] lk, input logic [NUM_REQ-1:0] exp_rdy,
                         input logic exp_locked);
        req_valid = v;
        req_lock  = lk;
        @(negedge clk);
        check({name, "_ready"}, 64'(req_ready), 64'(exp_rdy));
        check({name, "_locked"}, 64'(arb_locked), 64'(exp_locked));
        check({name, "_wr_en"}, 64'(rf_wr_en), 64'(prev_wr));
        prev_wr = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (exp_rdy[i] && (addr_r[i] != '0)) begin
                exp_q.push_back({addr_r[i], data_r[i]});
                prev_wr = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented write must match the head of the expected queue.
    initial begin
        logic [RAW+DW-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst && rf_wr_en) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write",
                             rf_wr_addr, rf_wr_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({rf_wr_addr, rf_wr_data} !== e) begin
                        fails++;
                        $display("FAIL write_data: got addr=%0h data=%0h expected addr=%0h data=%0h",
                                 rf_wr_addr, rf_wr_data, e[RAW+DW-1:DW], e[DW-1:0]);
                    end
                end
            end
        end
    end

    // Stimulus.
    initial begin
        logic [NUM_REQ-1:0] exp_g;
        tests     = 0;
        fails     = 0;
        prev_wr   = 1'b0;
        rst       = 1'b1;
        req_valid = '1;
        req_lock  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_r[i] = '0;
            data_r[i] = '0;
        end

        // Power-on reset: outputs cleared, ready held low despite valid requests.
        #2;
        check("por_en", 64'(rf_wr_en), 64'(0));
        check("por_addr", 64'(rf_wr_addr), 64'(0));
        check("por_data", 64'(rf_wr_data), 64'(0));
        check("por_locked", 64'(arb_locked), 64'(0));
        check("por_ready", 64'(req_ready), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;

        // Single write from requester 1.
        addr_r[1] = 5'd7;
        data_r[1] = 32'hDEADBEEF;
        cycle("single_t0", 3'b010, 3'b000, 3'b010, 1'b0);
        cycle("single_t1", 3'b000, 3'b000, 3'b000, 1'b0);
        cycle("single_t2", 3'b000, 3'b000, 3'b000, 1'b0);

        // Reset mid-traffic: the in-flight write is dropped at once.
        addr_r[1] = 5'd12;
        data_r[1] = 32'hCAFE0001;
        cycle("rst_pre", 3'b010, 3'b000, 3'b010, 1'b0);
        check("rst_pre_en", 64'(rf_wr_en), 64'(1));
        rst = 1'b1;
        exp_q.delete();
        prev_wr = 1'b0;
        #1;
        check("rst_mid_en", 64'(rf_wr_en), 64'(0));
        check("rst_mid_addr", 64'(rf_wr_addr), 64'(0));
        check("rst_mid_data", 64'(rf_wr_data), 64'(0));
        @(negedge clk);
        check("rst_mid_ready", 64'(req_ready), 64'(0));
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;

        // All three valid for six cycles.
        addr_r[0] = 5'd3;  data_r[0] = 32'h0000_0A00;
        addr_r[1] = 5'd4;  data_r[1] = 32'h0000_0B11;
        addr_r[2] = 5'd5;  data_r[2] = 32'h0000_0C22;
        for (int k = 0; k < 6; k++) begin
`ifdef RR_ARB_EN
            exp_g = 3'b001 << (k % 3);
`else
            exp_g = 3'b001;
`endif
            cycle("fair", 3'b111, 3'b000, exp_g, 1'b0);
        end

        // Locked burst: req0 holds for three beats, req2 waits then wins.
        addr_r[0] = 5'd10;
        addr_r[2] = 5'd20; data_r[2] = 32'h2020_2020;
        data_r[0] = 32'h1000_0001;
        cycle("lock_b1", 3'b101, 3'b001, 3'b001, 1'b0);
        data_r[0] = 32'h1000_0002;
        cycle("lock_b2", 3'b101, 3'b001, 3'b001, 1'b1);
        data_r[0] = 32'h1000_0003;
        cycle("lock_b3", 3'b101, 3'b000, 3'b001, 1'b1);
        cycle("lock_after", 3'b100, 3'b000, 3'b100, 1'b0);

        // Forced release after LOCK_MAX beats; owner-idle cycle stalls others.
        addr_r[1] = 5'd9;
        data_r[1] = 32'h0000_0101;
        cycle("max_b1", 3'b010, 3'b010, 3'b010, 1'b0);
        cycle("max_idle", 3'b001, 3'b010, 3'b000, 1'b1);
        for (int k = 2; k <= 4; k++) begin
            data_r[1] = 32'h0000_0100 + 32'(k);
            cycle("max_beat", 3'b011, 3'b010, 3'b010, 1'b1);
        end
        data_r[0] = 32'h0000_0E0E;
        cycle("max_release", 3'b011, 3'b010, 3'b001, 1'b0);

        // Zero register: accepted but never written; pointer still advances.
        addr_r[2] = 5'd0;
        data_r[2] = 32'h0000_1234;
        cycle("zero_t0", 3'b100, 3'b000, 3'b100, 1'b0);
        cycle("zero_t1", 3'b111, 3'b000, 3'b001, 1'b0);

        cycle("drain0", 3'b000, 3'b000, 3'b000, 1'b0);
        cycle("drain1", 3'b000, 3'b000, 3'b000, 1'b0);
        check("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
